// File: rtl/vedic_product_accumulator.sv
// rtl/vedic_product_accumulator.sv - sums a stream of 16-bit Vedic multiplier products
// The IDLE, ACCUM and HOLD states build one sum per in_last-terminated burst and hold it until it is consumed.
module vedic_product_accumulator #(
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      prod_in,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic [7:0]       term_cnt,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t           state_q;
  logic [ACC_W-1:0] acc_q;
  logic [7:0]       cnt_q;
  logic             ovf_q;
  logic             out_valid_q;

  logic             accept;
  logic [ACC_W:0]   sum_d;
  logic [7:0]       cnt_d;
  logic [ACC_W-1:0] first_d;

  // in_ready depends on state alone, so HOLD can never take a beat.
  assign in_ready = (state_q != HOLD);
  assign accept   = in_valid & in_ready;

  // Carry out of the top bit of sum_d is the overflow indication.
  assign sum_d   = {1'b0, acc_q} + {{(ACC_W + 1 - 16){1'b0}}, prod_in};
  assign cnt_d   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign first_d = {{(ACC_W - 16){1'b0}}, prod_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            acc_q <= first_d;
            cnt_q <= 8'd1;
            ovf_q <= 1'b0;
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (accept) begin
            acc_q <= sum_d[ACC_W-1:0];
            cnt_q <= cnt_d;
            if (sum_d[ACC_W]) begin
              ovf_q <= 1'b1;
            end
            if (in_last) begin
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          acc_q       <= '0;
          cnt_q       <= '0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out   = acc_q;
  assign term_cnt  = cnt_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_vedic_product_accumulator.sv
// tb/tb_vedic_product_accumulator.sv - scoreboard bench for vedic_product_accumulator
// Stimulus pushes hand-computed results into a queue; a negedge monitor pops one per consumed result.
module tb_vedic_product_accumulator;

  localparam int ACC_W = 24;

  typedef struct packed {
    logic [ACC_W-1:0] acc;
    logic [7:0]       cnt;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  logic [15:0]      prod_in;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [ACC_W-1:0] acc_out;
  logic [7:0]       term_cnt;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  vedic_product_accumulator #(.ACC_W(ACC_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .prod_in  (prod_in),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .acc_out  (acc_out),
    .term_cnt (term_cnt),
    .ovf      (ovf),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: a result is consumed when out_valid and out_ready are both high.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got acc=%0d cnt=%0d ovf=%0d, expected none", acc_out, term_cnt, ovf);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result_acc", 32'(acc_out), 32'(e.acc));
        check("result_cnt", 32'(term_cnt), 32'(e.cnt));
        check("result_ovf", 32'(ovf), 32'(e.ovf));
      end
    end
  end

  // Presents one beat and returns 1ns after the edge that accepts it.
  task automatic send(input logic [15:0] p, input logic last);
    int n;
    n = 0;
    in_valid = 1'b1;
    prod_in  = p;
    in_last  = last;
    while (!in_ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 100) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0, expected 1 within 100 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    prod_in   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_acc", 32'(acc_out), 32'd0);
    check("reset_cnt", 32'(term_cnt), 32'd0);
    check("reset_ovf", 32'(ovf), 32'd0);
    tick(2);
    rst = 1'b0;
    tick(1);

    // Single term, latency 1.
    exp_q.push_back('{acc: 24'd65025, cnt: 8'd1, ovf: 1'b0});
    send(16'd65025, 1'b1);
    check("single_out_valid", 32'(out_valid), 32'd1);
    check("single_in_ready", 32'(in_ready), 32'd0);
    tick(2);

    // Three terms with two idle cycles between beats.
    exp_q.push_back('{acc: 24'd65231, cnt: 8'd3, ovf: 1'b0});
    send(16'd6, 1'b0);
    tick(2);
    send(16'd200, 1'b0);
    tick(2);
    send(16'd65025, 1'b1);
    tick(2);

    // 258 terms: just below the wrap point, count saturated.
    exp_q.push_back('{acc: 24'd16776450, cnt: 8'd255, ovf: 1'b0});
    for (int i = 0; i < 258; i++) send(16'd65025, (i == 257));
    tick(2);

    // 259 terms: wraps, sticky overflow.
    exp_q.push_back('{acc: 24'd64259, cnt: 8'd255, ovf: 1'b1});
    for (int i = 0; i < 259; i++) send(16'd65025, (i == 258));
    tick(2);

    // Backpressure: HOLD ignores in_valid while out_ready is low.
    out_ready = 1'b0;
    exp_q.push_back('{acc: 24'd150, cnt: 8'd2, ovf: 1'b0});
    send(16'd100, 1'b0);
    send(16'd50, 1'b1);
    in_valid = 1'b1;
    prod_in  = 16'd777;
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_acc", 32'(acc_out), 32'd150);
      check("bp_cnt", 32'(term_cnt), 32'd2);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick(1);
    check("bp_release_out_valid", 32'(out_valid), 32'd0);
    check("bp_release_in_ready", 32'(in_ready), 32'd1);
    check("bp_release_acc", 32'(acc_out), 32'd0);
    tick(1);

    // Reset mid-sum after 2 of 4 beats.
    send(16'd1, 1'b0);
    send(16'd2, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_acc", 32'(acc_out), 32'd0);
    check("rst_mid_cnt", 32'(term_cnt), 32'd0);
    #2 rst = 1'b0;
    tick(1);
    exp_q.push_back('{acc: 24'd9, cnt: 8'd1, ovf: 1'b0});
    send(16'd9, 1'b1);
    tick(2);

    // Reset during HOLD discards the held result.
    out_ready = 1'b0;
    send(16'd5, 1'b1);
    check("rst_hold_pre_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_hold_out_valid", 32'(out_valid), 32'd0);
    check("rst_hold_in_ready", 32'(in_ready), 32'd1);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    tick(2);
    check("rst_hold_no_valid", 32'(out_valid), 32'd0);

    // Back-to-back sums with out_ready tied high.
    exp_q.push_back('{acc: 24'd3, cnt: 8'd2, ovf: 1'b0});
    exp_q.push_back('{acc: 24'd3, cnt: 8'd1, ovf: 1'b0});
    send(16'd1, 1'b0);
    send(16'd2, 1'b1);
    check("b2b_first_valid", 32'(out_valid), 32'd1);
    tick(1);
    check("b2b_idle_in_ready", 32'(in_ready), 32'd1);
    check("b2b_idle_out_valid", 32'(out_valid), 32'd0);
    send(16'd3, 1'b1);
    check("b2b_second_valid", 32'(out_valid), 32'd1);
    tick(3);

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vedic_product_accumulator.md
VEDIC_PRODUCT_ACCUMULATOR -- requirements
Module: vedic_product_accumulator

Interface
REQ-001 SHALL have parameter ACC_W, default 24, accumulator and result width in bits; legal range 17..32.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-004 SHALL have port prod_in, input, 16, unsigned product from the 8x8 Vedic multiplier stage.
REQ-005 SHALL have port in_valid, input, 1, prod_in is valid this cycle.
REQ-006 SHALL have port in_last, input, 1, the current beat is the final term of the sum; sampled only on an accepted beat.
REQ-007 SHALL have port in_ready, output, 1, the block can accept a beat this cycle.
REQ-008 SHALL have port acc_out, output, ACC_W, the completed sum.
REQ-009 SHALL have port term_cnt, output, 8, the number of terms in acc_out; saturates at 255.
REQ-010 SHALL have port ovf, output, 1, sticky flag set if the sum exceeded 2^ACC_W-1.
REQ-011 SHALL have port out_valid, output, 1, acc_out, term_cnt and ovf are valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts the result.

Function
REQ-013 SHALL treat a beat as accepted when in_valid and in_ready are both 1 on a rising clk edge.
REQ-014 SHALL implement the FSM states IDLE, ACCUM and HOLD.
REQ-015 SHALL in IDLE drive in_ready=1 and out_valid=0; an accepted beat SHALL load acc with prod_in zero-extended, set count=1 and clear ovf.
REQ-016 SHALL in IDLE go to HOLD if the accepted beat has in_last=1, and to ACCUM otherwise.
REQ-017 SHALL in ACCUM drive in_ready=1; an accepted beat SHALL set acc = (acc + prod_in) mod 2^ACC_W and increment count, saturating at 255.
REQ-018 SHALL set ovf to 1 in ACCUM when the addition carries out of bit ACC_W-1; ovf SHALL stay at 1 until the result is consumed.
REQ-019 SHALL in ACCUM go to HOLD when the accepted beat has in_last=1; with no accepted beat, state and acc SHALL hold.
REQ-020 SHALL in HOLD drive in_ready=0 and out_valid=1, with acc_out, term_cnt and ovf stable.
REQ-021 SHALL in HOLD, when out_ready=1, return to IDLE on that edge and clear acc, count and ovf to 0.
REQ-022 SHALL present the result with latency 1: out_valid rises on the edge that accepts the in_last beat.
REQ-023 SHALL drive in_ready combinationally from the state only, never from out_ready; HOLD never accepts a beat.
REQ-024 SHALL ignore in_valid and prod_in while in HOLD, with no state change.
REQ-025 SHALL make acc_out, term_cnt and ovf direct register outputs with no combinational path from inputs.
REQ-026 SHALL ignore prod_in and in_last whenever in_valid=0.

Reset
REQ-027 SHALL on rst=1, regardless of clk, force state to IDLE, acc and count to 0, and ovf and out_valid to 0; in_ready SHALL be 1.
REQ-028 SHALL on rst asserted mid-sum or during HOLD discard the partial or held result, with no out_valid pulse.
REQ-029 SHALL restart with a fresh sum on the first accepted beat after rst deasserts.

Verification
REQ-030 SHALL cover a single term: one beat with prod_in=65025 and in_last=1 -> next cycle out_valid=1, acc_out=65025, term_cnt=1, ovf=0.
REQ-031 SHALL cover a three-term sum: beats 6, 200 and 65025, the last with in_last=1, and in_valid gapped by 2 idle cycles -> acc_out=65231, term_cnt=3, ovf=0.
REQ-032 SHALL cover overflow at ACC_W=24: 259 beats of 65025 -> acc_out=64259 (wrapped), ovf=1, term_cnt=255; with 258 beats -> acc_out=16776450, ovf=0.
REQ-033 SHALL cover backpressure: out_ready held at 0 for 5 cycles in HOLD while in_valid=1 -> outputs stable, in_ready=0, no beat consumed; out_ready=1 -> IDLE on the next edge.
REQ-034 SHALL cover reset mid-sum: rst pulsed between clock edges after 2 of 4 beats -> out_valid=0 and in_ready=1 immediately; a new single beat of 9 with in_last=1 -> acc_out=9, term_cnt=1.
REQ-035 SHALL cover back-to-back sums: out_ready tied to 1 with sums {1,2} and then {3} -> results 3 and 3, term_cnt 2 and then 1; the IDLE cycle between sums is observed.
